// File: rtl/dac_req_pkg.sv
// -----------------------------------------------------------------------------
// dac_req_pkg
// Shared definitions for the CPU-side DAC request initiator:
//   - DAC_WIDTH : default duty-cycle sample width, shared with the PWM-domain DAC
//   - dac_req_state_e : four-phase handshake FSM state encoding
// -----------------------------------------------------------------------------
package dac_req_pkg;

   // Duty-cycle width used by the DAC; the initiator's WIDTH defaults to it.
   localparam int DAC_WIDTH = 12;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_ASSERT  = 2'd2,
      ST_RELEASE = 2'd3
   } dac_req_state_e;

endpackage : dac_req_pkg

// File: rtl/dac_req_fifo.sv
// -----------------------------------------------------------------------------
// dac_req_fifo
// Synchronous FIFO buffering duty-cycle samples between the CPU MMIO path and
// the handshake FSM. Read data is the current head (show-ahead); there is no
// push-to-pop bypass, so a sample pushed into an empty FIFO is poppable on the
// following cycle.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (pointers and count clear)
//   push       in   write push_data (ignored when full)
//   push_data  in   sample to write
//   pop        in   advance the head (ignored when empty)
//   pop_data   out  current head entry
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   level      out  occupancy, 0..DEPTH
// Parameters:
//   WIDTH  entry width
//   DEPTH  entries, power of two >= 2
// -----------------------------------------------------------------------------
module dac_req_fifo
   import dac_req_pkg::*;
#(
   parameter int WIDTH = DAC_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read when count says valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign pop_data = mem[rd_ptr];
   assign level    = count;

endmodule : dac_req_fifo

// File: rtl/dac_req_sync.sv
// -----------------------------------------------------------------------------
// dac_req_sync
// Multi-flop level synchronizer for a single asynchronous bit.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset (all stages clear to 0)
//   d    in   asynchronous input
//   q    out  synchronized output, STAGES clk edges of latency
// Parameters:
//   STAGES  number of flops in the chain (>= 2)
// -----------------------------------------------------------------------------
module dac_req_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[STAGES-2:0], d};
      end
   end

   assign q = sync_ff[STAGES-1];

endmodule : dac_req_sync

// File: rtl/dac_req_initiator.sv
// -----------------------------------------------------------------------------
// dac_req_initiator
// CPU-clock-side (cpu_clk_g) initiator for the four-phase req/ack duty-cycle
// interface of the PWM-domain DAC. Samples arrive over valid/ready, are
// buffered in a small FIFO, and each one is delivered by holding duty_cycle
// stable while req/ack complete a full four-phase handshake.
//
// Input handshake: a sample transfers on every clk edge where in_valid and
// in_ready are both high; in_ready is !full and does not depend on in_valid.
//
// Optional feature: define DAC_REQ_TIMEOUT_EN to add a handshake timeout of
// TIMEOUT_CYCLES clk cycles in ASSERT and RELEASE with a sticky timeout_err.
// Without it, timeout_err is 0 and the FSM waits on ack indefinitely.
//
// Ports:
//   clk          in   CPU clock
//   rst          in   asynchronous active-high reset
//   in_data      in   sample from CPU
//   in_valid     in   in_data valid
//   in_ready     out  FIFO can accept (!full)
//   duty_cycle   out  registered sample presented to the DAC
//   req          out  registered four-phase request
//   ack          in   DAC acknowledge, asynchronous to clk
//   busy         out  FSM not IDLE or FIFO non-empty
//   level        out  FIFO occupancy
//   timeout_err  out  sticky handshake timeout flag
// -----------------------------------------------------------------------------
module dac_req_initiator
   import dac_req_pkg::*;
#(
   parameter int WIDTH          = DAC_WIDTH,
   parameter int DEPTH          = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       duty_cycle,
   output logic                   req,
   input  logic                   ack,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   timeout_err
);

   localparam bit PARAMS_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
                              (SYNC_STAGES >= 2) && (TIMEOUT_CYCLES >= 2);

   if (!PARAMS_OK) begin : g_bad_params
      $error("dac_req_initiator: invalid DEPTH, SYNC_STAGES or TIMEOUT_CYCLES");
   end

   // Handshake FSM state, kept as a named signal so checkers can bind to it.
   dac_req_state_e state_q;

   logic             ack_s;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_head;
   logic             fifo_push;
   logic             fifo_pop;

   // ack crosses from the PWM domain; nothing else looks at raw ack.
   dac_req_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack),
      .q   (ack_s)
   );

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;

   // The ack_s guard keeps a stale ack (e.g. DAC still high after our reset)
   // from starting a transfer before the DAC has returned to zero.
   assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && !ack_s;

   dac_req_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   assign busy = (state_q != ST_IDLE) || !fifo_empty;

`ifdef DAC_REQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0] tmo_cnt;
   logic          tmo_err_q;
   logic          tmo_hit;

   // The counter starts at 0 on state entry, so the hit value is LIMIT-1:
   // the state lasts exactly TIMEOUT_CYCLES cycles before giving up.
   assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req        <= 1'b0;
         duty_cycle <= '0;
`ifdef DAC_REQ_TIMEOUT_EN
         tmo_cnt    <= '0;
         tmo_err_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  duty_cycle <= fifo_head;
                  state_q    <= ST_SETUP;
               end
            end

            // One cycle of data setup so duty_cycle settles before req rises.
            ST_SETUP: begin
               req     <= 1'b1;
               state_q <= ST_ASSERT;
`ifdef DAC_REQ_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end

            // An early ack (seen already in IDLE/SETUP) lands here and is
            // accepted on the first ASSERT cycle.
            ST_ASSERT: begin
               if (ack_s) begin
                  req     <= 1'b0;
                  state_q <= ST_RELEASE;
`ifdef DAC_REQ_TIMEOUT_EN
                  tmo_cnt <= '0;
               end else if (tmo_hit) begin
                  // Sample is abandoned, not retried.
                  req       <= 1'b0;
                  tmo_err_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
`endif
               end
            end

            ST_RELEASE: begin
               if (!ack_s) begin
                  state_q <= ST_IDLE;
`ifdef DAC_REQ_TIMEOUT_EN
               end else if (tmo_hit) begin
                  // IDLE still refuses to start while ack_s stays high.
                  tmo_err_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
`endif
               end
            end

            default: begin
               req     <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : dac_req_initiator

// File: tb/tb_dac_req_initiator.sv
// -----------------------------------------------------------------------------
// tb_dac_req_initiator
// Directed bench for dac_req_initiator. Pushed samples go into exp_q; a
// monitor pops and compares duty_cycle on every req rising edge. A DAC model
// answers req according to dac_mode. Timing checks are hand-derived from a
// 2-flop ack synchronizer plus registered FSM outputs, with ack driven 1 time
// unit after a rising clk edge.
// -----------------------------------------------------------------------------
module tb_dac_req_initiator;

   localparam int WIDTH          = 12;
   localparam int DEPTH          = 4;
   localparam int SYNC_STAGES    = 2;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int LW             = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] duty_cycle;
   logic             req;
   logic             ack;
   logic             busy;
   logic [LW-1:0]    level;
   logic             timeout_err;

   always #5 clk = ~clk;

   dac_req_initiator #(
      .WIDTH          (WIDTH),
      .DEPTH          (DEPTH),
      .SYNC_STAGES    (SYNC_STAGES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .duty_cycle  (duty_cycle),
      .req         (req),
      .ack         (ack),
      .busy        (busy),
      .level       (level),
      .timeout_err (timeout_err)
   );

   // ---------------- scoreboard state ----------------
   int               checks    = 0;
   int               failures  = 0;
   int               delivered = 0;
   logic [WIDTH-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- DAC model ----------------
   // dac_mode: 0 = four-phase responder, 1 = hold ack low, 2 = hold ack high
   int dac_mode = 1;
   int rise_dly = 5;
   int fall_dly = 5;
   int dac_cnt  = 0;

   initial begin
      ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (dac_mode)
            0: begin
               if (req && !ack) begin
                  if (dac_cnt >= rise_dly) begin ack = 1'b1; dac_cnt = 0; end
                  else dac_cnt++;
               end else if (!req && ack) begin
                  if (dac_cnt >= fall_dly) begin ack = 1'b0; dac_cnt = 0; end
                  else dac_cnt++;
               end else begin
                  dac_cnt = 0;
               end
            end
            1:       begin ack = 1'b0; dac_cnt = 0; end
            default: begin ack = 1'b1; dac_cnt = 0; end
         endcase
      end
   end

   // ---------------- monitor ----------------
   logic             req_prev = 1'b0;
   logic [WIDTH-1:0] dc_prev   = '0;
   logic [WIDTH-1:0] mon_exp;

   always @(negedge clk) begin
      if (!rst) begin
         if (req && !req_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_req: duty_cycle=0x%0h with no sample required", duty_cycle);
            end else begin
               mon_exp = exp_q.pop_front();
               delivered++;
               if (duty_cycle !== mon_exp) begin
                  failures++;
                  $display("FAIL req_rise_data: got 0x%0h required 0x%0h", duty_cycle, mon_exp);
               end
            end
         end
         if (req && req_prev) begin
            checks++;
            if (duty_cycle !== dc_prev) begin
               failures++;
               $display("FAIL duty_stable: got 0x%0h required 0x%0h", duty_cycle, dc_prev);
            end
         end
      end
      req_prev = req;
      dc_prev  = duty_cycle;
   end

   // ---------------- driver tasks ----------------
   task automatic push_try(input logic [WIDTH-1:0] v, output bit acc);
      @(negedge clk);
      in_data  = v;
      in_valid = 1'b1;
      acc      = in_ready;
      if (acc) exp_q.push_back(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic push_wait(input logic [WIDTH-1:0] v, input int max);
      bit acc = 1'b0;
      for (int i = 0; i < max && !acc; i++) push_try(v, acc);
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL push_wait: sample 0x%0h not accepted within %0d cycles", v, max);
      end
   endtask

   // sel: 0 busy, 1 req, 2 ack, 3 duty_cycle. Returns at the first negedge
   // where the signal equals val.
   task automatic wait_sig(input string name, input int sel, input logic [31:0] val, input int max);
      bit hit = 1'b0;
      for (int i = 0; i < max && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = (32'(busy) === val);
            1:       hit = (32'(req) === val);
            2:       hit = (32'(ack) === val);
            default: hit = (32'(duty_cycle) === val);
         endcase
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL %s: timed out after %0d cycles, required 0x%0h", name, max, val);
      end
   endtask

   // ---------------- stimulus ----------------
   bit acc;
   int cnt;
   int bad;
   int base;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",    32'(in_ready),    32'd1);
      chk("rst_duty_cycle",  32'(duty_cycle),  32'd0);
      chk("rst_req",         32'(req),         32'd0);
      chk("rst_busy",        32'(busy),        32'd0);
      chk("rst_level",       32'(level),       32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst = 1'b0;

      // Single transfer with a 5-cycle DAC.
      dac_mode = 0; rise_dly = 5; fall_dly = 5;
      push_try(12'hABC, acc);
      chk("t1_accept", 32'(acc), 32'd1);
      wait_sig("t1_duty_load", 3, 32'hABC, 20);
      chk("t1_req_low_in_setup", 32'(req), 32'd0);
      @(negedge clk);
      chk("t1_req_rise", 32'(req), 32'd1);
      wait_sig("t1_ack_rise", 2, 32'd1, 40);
      repeat (2) @(negedge clk);
      chk("t1_req_still_high", 32'(req), 32'd1);
      @(negedge clk);
      chk("t1_req_fall", 32'(req), 32'd0);
      wait_sig("t1_ack_fall", 2, 32'd0, 40);
      repeat (2) @(negedge clk);
      chk("t1_busy_in_release", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_busy_low", 32'(busy), 32'd0);
      chk("t1_level", 32'(level), 32'd0);

      // Backpressure: DAC never acks, one sample in flight, four buffered.
      dac_mode = 1;
      for (int v = 1; v <= 6; v++) begin
         push_try(WIDTH'(v), acc);
         chk($sformatf("t2_accept_%0d", v), 32'(acc), (v <= 5) ? 32'd1 : 32'd0);
      end
      chk("t2_level_full", 32'(level),    32'd4);
      chk("t2_in_ready",   32'(in_ready), 32'd0);
      chk("t2_req_high",   32'(req),      32'd1);
      dac_mode = 0;
      wait_sig("t2_drain", 0, 32'd0, 400);
      chk("t2_all_delivered", 32'(exp_q.size()), 32'd0);

      // Stale ack across reset.
      dac_mode = 1;
      push_try(12'h111, acc);
      wait_sig("t3_req_up", 1, 32'd1, 20);
      push_try(12'h222, acc);
      push_try(12'h333, acc);
      @(negedge clk);
      dac_mode = 2;
      @(negedge clk);
      chk("t3_ack_before_rst", 32'(ack), 32'd1);
      rst = 1'b1;
      #1;
      chk("t3_req_async_clear",  32'(req),        32'd0);
      chk("t3_duty_clear",       32'(duty_cycle), 32'd0);
      chk("t3_level_clear",      32'(level),      32'd0);
      chk("t3_in_ready",         32'(in_ready),   32'd1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_try(12'h123, acc);
      chk("t3_accept", 32'(acc), 32'd1);
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (req !== 1'b0) bad++;
      end
      chk("t3_no_req_while_ack_high", 32'(bad), 32'd0);
      @(negedge clk);
      dac_mode = 1;
      @(posedge clk);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (req !== 1'b0) bad++;
      end
      chk("t3_no_early_req", 32'(bad), 32'd0);
      @(negedge clk);
      chk("t3_req_after_sync", 32'(req), 32'd1);
      chk("t3_duty", 32'(duty_cycle), 32'h123);
      dac_mode = 0;
      wait_sig("t3_drain", 0, 32'd0, 100);

      // Simultaneous push and pop at level 2.
      dac_mode = 2;
      repeat (4) @(negedge clk);
      push_try(12'h0B1, acc);
      push_try(12'h0C2, acc);
      chk("t4_level_before", 32'(level), 32'd2);
      chk("t4_blocked_req",  32'(req),   32'd0);
      @(negedge clk);
      dac_mode = 1;
      repeat (3) @(posedge clk);
      push_try(12'h0D3, acc);
      chk("t4_accept",        32'(acc),        32'd1);
      chk("t4_level_same",    32'(level),      32'd2);
      chk("t4_duty_popped",   32'(duty_cycle), 32'h0B1);
      dac_mode = 0;
      wait_sig("t4_drain", 0, 32'd0, 200);
      chk("t4_all_delivered", 32'(exp_q.size()), 32'd0);

      // Wrap-around: 3*DEPTH samples with an immediate-ack DAC.
      dac_mode = 0; rise_dly = 0; fall_dly = 0;
      base = delivered;
      for (int v = 0; v < 3 * DEPTH; v++) push_wait(WIDTH'(v), 100);
      wait_sig("t5_drain", 0, 32'd0, 200);
      chk("t5_all_delivered", 32'(exp_q.size()),     32'd0);
      chk("t5_count",         32'(delivered - base), 32'(3 * DEPTH));

`ifdef DAC_REQ_TIMEOUT_EN
      chk("t6_err_clear", 32'(timeout_err), 32'd0);
      dac_mode = 1;
      push_try(12'h5A5, acc);
      wait_sig("t6_req_up", 1, 32'd1, 20);
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req) cnt++;
         else break;
      end
      chk("t6_req_high_cycles", 32'(cnt), 32'(TIMEOUT_CYCLES));
      chk("t6_err_set", 32'(timeout_err), 32'd1);
      repeat (5) @(negedge clk);
      chk("t6_err_sticky", 32'(timeout_err), 32'd1);
      dac_mode = 0; rise_dly = 2; fall_dly = 2;
      push_try(12'h6B6, acc);
      wait_sig("t6_drain", 0, 32'd0, 100);
      chk("t6_recovered",     32'(exp_q.size()), 32'd0);
      chk("t6_err_still_set", 32'(timeout_err),  32'd1);
`else
      chk("t6_err_tied_low", 32'(timeout_err), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_dac_req_initiator
